// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian 32-bit words from a byte stream and writes them to imem.
// Optional trailer checksum verification when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_size_o,
    output logic              cpu_hold_o,
    output logic              checksum_err_o
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StFin} state_e;

    state_e           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      asm_q, asm_d;
    logic             err_size_q, err_size_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             cksum_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
    logic             trailer_q, trailer_d;
    logic             cksum_err_q, cksum_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        asm_d      = asm_q;
        err_size_d = err_size_q;
        cpu_hold_d = cpu_hold_q;
        cksum_ok   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        trailer_d   = trailer_q;
        cksum_err_d = cksum_err_q;
        // Only consulted in StFin, where asm_q holds the received trailer.
        cksum_ok    = (asm_q == sum_q);
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (word_count_i > CNT_W'(DEPTH)) begin
                        err_size_d = 1'b1;
                    end else begin
                        count_d    = word_count_i;
                        byte_cnt_d = '0;
                        word_idx_d = '0;
                        asm_d      = '0;
                        err_size_d = 1'b0;
                        cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d       = '0;
                        cksum_err_d = 1'b0;
                        trailer_d   = (word_count_i == '0);
                        state_d     = StRecv;
`else
                        state_d     = (word_count_i == '0) ? StFin : StRecv;
`endif
                    end
                end
            end
            StRecv: begin
                if (byte_valid_i) begin
                    asm_d      = {asm_q[23:0], byte_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = trailer_q ? StFin : StWrite;
`else
                        state_d = StWrite;
`endif
                    end
                end
            end
            StWrite: begin
                byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d = sum_q + asm_q;
`endif
                if (word_idx_q + CNT_W'(1) == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    trailer_d = 1'b1;
                    state_d   = StRecv;
`else
                    state_d   = StFin;
`endif
                end else begin
                    word_idx_d = word_idx_q + CNT_W'(1);
                    state_d    = StRecv;
                end
            end
            StFin: begin
                state_d = StIdle;
                if (cksum_ok) begin
                    cpu_hold_d = 1'b0;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                else begin
                    cksum_err_d = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            asm_q      <= '0;
            err_size_q <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            trailer_q   <= 1'b0;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            asm_q      <= asm_d;
            err_size_q <= err_size_d;
            cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            trailer_q   <= trailer_d;
            cksum_err_q <= cksum_err_d;
`endif
        end
    end

    assign byte_ready_o = (state_q == StRecv);
    assign imem_we_o    = (state_q == StWrite);
    assign imem_waddr_o = word_idx_q[ADDR_W-1:0];
    assign imem_wdata_o = asm_q;
    assign busy_o       = (state_q == StRecv) || (state_q == StWrite);
    assign done_o       = (state_q == StFin) && cksum_ok;
    assign err_size_o   = err_size_q;
    // Drop the hold in the completion cycle itself, not one cycle later.
    assign cpu_hold_o   = cpu_hold_q && !done_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum_err_o = cksum_err_q;
`else
    assign checksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream reference model.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the trailer checksum.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned CNT_W  = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit Ck = 1'b1;
`else
    localparam bit Ck = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [CNT_W-1:0]  word_count_i = '0;
    logic              byte_valid_i = 1'b0;
    logic [7:0]        byte_data_i = '0;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_waddr_o;
    logic [31:0]       imem_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              err_size_o;
    logic              cpu_hold_o;
    logic              checksum_err_o;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .word_count_i   (word_count_i),
        .byte_valid_i   (byte_valid_i),
        .byte_data_i    (byte_data_i),
        .byte_ready_o   (byte_ready_o),
        .imem_we_o      (imem_we_o),
        .imem_waddr_o   (imem_waddr_o),
        .imem_wdata_o   (imem_wdata_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_size_o     (err_size_o),
        .cpu_hold_o     (cpu_hold_o),
        .checksum_err_o (checksum_err_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wbuf [0:DEPTH-1];
    logic        exp_hold = 1'b1;
    logic        exp_cerr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"}, 32'(imem_we_o), 32'd0);
        check({tag, "_waddr"}, 32'(imem_waddr_o), 32'd0);
        check({tag, "_wdata"}, imem_wdata_o, 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err_size"}, 32'(err_size_o), 32'd0);
        check({tag, "_cerr"}, 32'(checksum_err_o), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
    endtask

    // Streams n words from wbuf (plus trailer when checksum is built in) and checks every
    // cycle against the expected handshake/write/completion timing.
    task automatic run_load(input int n, input int gap_mode, input bit bad_trl,
                            input int abort_at, input int inject_at);
        logic [7:0]  bytes [$];
        logic [31:0] sum = 32'd0;
        logic [31:0] trl;
        int          total, bptr = 0, widx = 0, nwr = 0, cyc = 0, budget;
        bit          we_pend = 1'b0, fin_pend, exp_ready, next_we, next_fin;
        bit          finished = 1'b0, valid, ok;
        ok = !(Ck && bad_trl);
        for (int i = 0; i < n; i++) begin
            sum += wbuf[i];
            bytes.push_back(wbuf[i][31:24]);
            bytes.push_back(wbuf[i][23:16]);
            bytes.push_back(wbuf[i][15:8]);
            bytes.push_back(wbuf[i][7:0]);
        end
        trl = bad_trl ? sum + 32'd1 : sum;
        if (Ck) begin
            bytes.push_back(trl[31:24]);
            bytes.push_back(trl[23:16]);
            bytes.push_back(trl[15:8]);
            bytes.push_back(trl[7:0]);
        end
        total    = bytes.size();
        budget   = 6 * total + 20;
        fin_pend = (total == 0);
        @(negedge clk);
        start_i      = 1'b1;
        word_count_i = CNT_W'(n);
        while (!finished) begin
            @(negedge clk);
            start_i = (inject_at > 0) && (cyc == inject_at);
            if (start_i) word_count_i = CNT_W'(5);
            if (abort_at > 0 && bptr >= abort_at) begin
                rst_n        = 1'b0;
                byte_valid_i = 1'b0;
                #1;
                check_reset_values("abort");
                check("abort_nwrites", 32'(nwr), 32'(abort_at / 4));
                @(negedge clk);
                rst_n    = 1'b1;
                exp_hold = 1'b1;
                exp_cerr = 1'b0;
                return;
            end
            cyc++;
            if (cyc > budget) begin
                check("timeout", 32'd1, 32'd0);
                finished = 1'b1;
            end else begin
                if (imem_we_o) nwr++;
                check("we", 32'(imem_we_o), 32'(we_pend));
                check("err_size_clr", 32'(err_size_o), 32'd0);
                if (we_pend) begin
                    check("waddr", 32'(imem_waddr_o), 32'(widx));
                    check("wdata", imem_wdata_o, wbuf[widx]);
                    widx++;
                end
                if (fin_pend) begin
                    check("done", 32'(done_o), 32'(ok));
                    check("hold_fin", 32'(cpu_hold_o), 32'(!ok));
                    check("busy_fin", 32'(busy_o), 32'd0);
                    finished = 1'b1;
                end else begin
                    check("busy", 32'(busy_o), 32'd1);
                    check("done_early", 32'(done_o), 32'd0);
                    check("hold_load", 32'(cpu_hold_o), 32'd1);
                end
                exp_ready = !fin_pend && !we_pend && (bptr < total);
                check("ready", 32'(byte_ready_o), 32'(exp_ready));
                next_we  = 1'b0;
                next_fin = we_pend && (widx == n) && !Ck;
                if (!finished && bptr < total) begin
                    case (gap_mode)
                        0:       valid = 1'b1;
                        1:       valid = cyc[0];
                        default: valid = ($urandom_range(0, 2) != 0);
                    endcase
                end else begin
                    valid = 1'b0;
                end
                byte_valid_i = valid;
                byte_data_i  = (bptr < total) ? bytes[bptr] : 8'($urandom);
                if (valid && exp_ready) begin
                    bptr++;
                    if (bptr % 4 == 0) begin
                        if (Ck && bptr == total) next_fin = 1'b1;
                        else next_we = 1'b1;
                    end
                end
                we_pend  = next_we;
                fin_pend = next_fin;
            end
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        check("nwrites", 32'(nwr), 32'(n));
        exp_hold = !ok;
        exp_cerr = Ck && bad_trl;
        @(negedge clk);
        check("hold_after", 32'(cpu_hold_o), 32'(exp_hold));
        check("cerr_after", 32'(checksum_err_o), 32'(exp_cerr));
        check("busy_after", 32'(busy_o), 32'd0);
        check("done_after", 32'(done_o), 32'd0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        wbuf[0] = 32'h3C081001;
        wbuf[1] = 32'h20080005;
        run_load(2, 0, 1'b0, 0, 0);
        run_load(2, 1, 1'b0, 0, 0);

        // Oversize request: flagged, no activity, hold unchanged.
        @(negedge clk);
        start_i      = 1'b1;
        word_count_i = CNT_W'(DEPTH + 1);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("err_size_set", 32'(err_size_o), 32'd1);
            check("err_we", 32'(imem_we_o), 32'd0);
            check("err_busy", 32'(busy_o), 32'd0);
            check("err_ready", 32'(byte_ready_o), 32'd0);
            check("err_hold", 32'(cpu_hold_o), 32'(exp_hold));
            @(negedge clk);
        end
        fill_random(1);
        run_load(1, 2, 1'b0, 0, 0);

        fill_random(3);
        run_load(3, 0, 1'b0, 6, 0);

        fill_random(2);
        run_load(2, 2, 1'b0, 0, 5);

        run_load(0, 0, 1'b0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            fill_random(n);
            run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
        end

        fill_random(DEPTH);
        run_load(DEPTH, 0, 1'b0, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wbuf[0] = 32'h00000001;
        run_load(1, 0, 1'b0, 0, 0);
        run_load(1, 0, 1'b1, 0, 0);
        run_load(1, 1, 1'b0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words.
- Writes each word into the instruction-memory write port at consecutive word addresses starting at 0.
- Holds the CPU in reset (cpu_hold) until the programmed number of words has been loaded. Sits between the boot UART/host link and the instruction RAM.

Parameters:
- ADDR_W, 11, word-address width of instruction memory.
- DEPTH, 2048, number of instruction words; max loadable count.
- CNT_W, 12, width of word_count and load counters (must hold DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- word_count  input  CNT_W  number of words to load; latched on accepted start.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming program byte, MSB-first per word.
- byte_ready  output  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready).
- imem_we  output  1  write strobe to instruction memory, one cycle per word.
- imem_waddr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word being written.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse on successful load completion.
- err_size  output  1  sticky: word_count > DEPTH requested; cleared by next accepted start.
- cpu_hold  output  1  CPU reset hold; high out of reset, low only after a successful load.
- checksum_err  output  1  see Optional Feature; constant 0 when compiled out.

Behaviour:
- Reset (async, rst_n=0): state IDLE; byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err_size=0, checksum_err=0, cpu_hold=1; byte counter, word counter and assembly register=0.
- States: IDLE, RECV, WRITE, FIN.
- IDLE → RECV: when start=1 and 1 ≤ word_count ≤ DEPTH. Latch word_count, clear counters and errors, set busy=1, assert cpu_hold=1.
- IDLE → FIN: when start=1 and word_count=0. No writes occur.
- IDLE, size error: when start=1 and word_count > DEPTH, set err_size=1 and stay in IDLE. No writes; cpu_hold unchanged.
- RECV: byte_ready=1. Each transfer shifts the byte into the assembly register: first byte → [31:24], fourth byte → [7:0]. After the 4th transfer, go to WRITE.
- WRITE (exactly 1 cycle): imem_we=1, imem_waddr=word index, imem_wdata=assembled word, byte_ready=0.
  - Next state: word index+1 == latched count → FIN; otherwise RECV, with index incremented and byte counter cleared.
- FIN (1 cycle): done=1 pulse, cpu_hold=0, busy=0 → IDLE. A failed checksum (Optional Feature) suppresses done and keeps cpu_hold=1.
- Write latency: imem_we asserts on the cycle after the 4th byte transfer.
- Throughput: at most 1 word per 5 cycles.
- byte_valid gaps: allowed anywhere; the loader waits in RECV without timeout.
- start while busy: ignored.
- imem_waddr: never exceeds DEPTH-1; no wrap.
- cpu_hold after a completed load: stays 0 until reset or the next accepted start.
- rst_n asserted mid-load: immediate return to reset values. Partially written memory is not rolled back; cpu_hold=1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Keep a 32-bit modulo-2^32 running sum of every word written.
  - After the last WRITE, return to RECV to receive one extra 4-byte trailer word. The trailer is not written to memory.
  - Trailer == sum: FIN behaves normally.
  - Trailer != sum: FIN sets checksum_err=1 (sticky until next accepted start), done stays 0, cpu_hold stays 1, busy=0.
  - word_count=0 with the feature: expects the trailer 0x00000000.
- Undefined: no trailer, no sum register, checksum_err tied 0.

Test Plan:
- Reset, then start with word_count=2, bytes 3C 08 10 01 20 08 00 05 → writes addr0=0x3C081001, addr1=0x20080005. imem_we high exactly 2 cycles; done pulse once; cpu_hold 1→0.
- Same load with byte_valid toggled 1/0 every cycle → identical writes; byte_ready=0 during each WRITE cycle.
- start with word_count=2049 → err_size=1; no imem_we; state stays IDLE. A following start with word_count=1 clears err_size and loads.
- rst_n pulsed low after 6 bytes of a 3-word load → outputs at reset values immediately; cpu_hold=1. Only addr0 was written.
- start pulsed during RECV with word_count=5 → ignored; load finishes with the original count.
- IMEM_LOADER_CHECKSUM_EN, word_count=1, word 0x00000001:
  - trailer 00 00 00 01 → done=1, cpu_hold=0.
  - trailer 00 00 00 02 → checksum_err=1, done stays 0, cpu_hold=1.
